// File: rtl/arm_write_buffer.sv
// arm_write_buffer: posted-store FIFO in front of the data memory write port, with load forwarding.
// Define ARM_WRITE_BUFFER_COALESCE_EN to merge stores to a word that is already buffered.
module arm_write_buffer #(
   parameter int BusWidth = 32,
   parameter int Depth    = 4
) (
   input  logic                       i_CLK,
   input  logic                       i_RESET_N,
   input  logic                       i_Store_Valid,
   input  logic [BusWidth-1:0]        i_Store_Addr,
   input  logic [BusWidth-1:0]        i_Store_Data,
   output logic                       o_Store_Ready,
   input  logic                       i_Load_Valid,
   input  logic [BusWidth-1:0]        i_Load_Addr,
   output logic [BusWidth-1:0]        o_Load_Data,
   output logic                       o_Load_Hit,
   output logic                       o_Mem_Write_Enable,
   output logic [BusWidth-1:0]        o_Mem_Address,
   output logic [BusWidth-1:0]        o_Mem_Write_Data,
   input  logic [BusWidth-1:0]        i_Mem_Read_Data,
   output logic                       o_Empty,
   output logic                       o_Full,
   output logic [$clog2(Depth+1)-1:0] o_Count
);
   localparam int PtrW  = $clog2(Depth);
   localparam int CntW  = $clog2(Depth+1);
   localparam int WordW = BusWidth - 2;

   logic [WordW-1:0]    entryAddr_q [Depth];
   logic [BusWidth-1:0] entryData_q [Depth];
   logic [PtrW-1:0]     head_q, head_d;
   logic [PtrW-1:0]     tail_q, tail_d;
   logic [CntW-1:0]     count_q, count_d;

   logic [WordW-1:0] storeWord;
   logic [WordW-1:0] loadWord;
   logic             full;
   logic             empty;
   logic             drain;
   logic             accept;
   logic             alloc;
   logic             coalesce;
   logic             loadMatch;
   logic [PtrW-1:0]  loadIdx;
   logic             unusedAddrBits;

   assign storeWord      = i_Store_Addr[BusWidth-1:2];
   assign loadWord       = i_Load_Addr[BusWidth-1:2];
   assign unusedAddrBits = ^{i_Store_Addr[1:0], i_Load_Addr[1:0]};

   assign full  = (count_q == CntW'(Depth));
   assign empty = (count_q == '0);
   assign drain = !i_Load_Valid && !empty;

   // Entries are walked oldest to youngest, so the last match found is the youngest one.
   always_comb begin
      logic [PtrW-1:0] idx;
      idx       = '0;
      loadMatch = 1'b0;
      loadIdx   = '0;
      for (int k = 0; k < Depth; k++) begin
         idx = head_q + PtrW'(k);
         if (CntW'(k) < count_q && entryAddr_q[idx] == loadWord) begin
            loadMatch = 1'b1;
            loadIdx   = idx;
         end
      end
   end

`ifdef ARM_WRITE_BUFFER_COALESCE_EN
   logic            storeMatch;
   logic [PtrW-1:0] storeIdx;

   always_comb begin
      logic [PtrW-1:0] idx;
      idx        = '0;
      storeMatch = 1'b0;
      storeIdx   = '0;
      for (int k = 0; k < Depth; k++) begin
         idx = head_q + PtrW'(k);
         if (CntW'(k) < count_q && entryAddr_q[idx] == storeWord) begin
            storeMatch = 1'b1;
            storeIdx   = idx;
         end
      end
   end

   // A head entry leaving this cycle cannot absorb the store; it gets a fresh slot instead.
   assign coalesce      = storeMatch && !(drain && storeIdx == head_q);
   assign o_Store_Ready = !full || coalesce;
`else
   assign coalesce      = 1'b0;
   assign o_Store_Ready = !full;
`endif

   assign accept = i_Store_Valid && o_Store_Ready;
   assign alloc  = accept && !coalesce;

   always_comb begin
      head_d  = drain ? head_q + PtrW'(1) : head_q;
      tail_d  = alloc ? tail_q + PtrW'(1) : tail_q;
      count_d = count_q;
      if (alloc && !drain) begin
         count_d = count_q + CntW'(1);
      end else if (drain && !alloc) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payloads carry no reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge i_CLK) begin
      if (alloc) begin
         entryAddr_q[tail_q] <= storeWord;
         entryData_q[tail_q] <= i_Store_Data;
      end
`ifdef ARM_WRITE_BUFFER_COALESCE_EN
      else if (accept) begin
         entryData_q[storeIdx] <= i_Store_Data;
      end
`endif
   end

   always_comb begin
      o_Mem_Address = i_Load_Addr;
      if (drain) begin
         o_Mem_Address = {entryAddr_q[head_q], 2'b00};
      end
   end

   assign o_Mem_Write_Enable = drain;
   assign o_Mem_Write_Data   = entryData_q[head_q];
   assign o_Load_Hit         = i_Load_Valid && loadMatch;
   assign o_Load_Data        = o_Load_Hit ? entryData_q[loadIdx] : i_Mem_Read_Data;

   assign o_Empty = empty;
   assign o_Full  = full;
   assign o_Count = count_q;

endmodule

// File: tb/tb_arm_write_buffer.sv
// tb_arm_write_buffer: directed and random stimulus for arm_write_buffer against a queue-based model.
// Build with ARM_WRITE_BUFFER_COALESCE_EN defined to exercise the coalescing variant.
module tb_arm_write_buffer;
   localparam int BusWidth = 32;
   localparam int Depth    = 4;
   localparam int CntW     = $clog2(Depth+1);

   logic                clk = 1'b0;
   logic                rstN;
   logic                storeValid;
   logic [BusWidth-1:0] storeAddr;
   logic [BusWidth-1:0] storeData;
   logic                storeReady;
   logic                loadValid;
   logic [BusWidth-1:0] loadAddr;
   logic [BusWidth-1:0] loadData;
   logic                loadHit;
   logic                memWe;
   logic [BusWidth-1:0] memAddr;
   logic [BusWidth-1:0] memWData;
   logic [BusWidth-1:0] memRData;
   logic                empty;
   logic                full;
   logic [CntW-1:0]     count;

   typedef struct packed {
      logic [29:0] word;
      logic [31:0] data;
   } entry_t;

   entry_t      model[$];
   logic [31:0] memArr [256];
   logic [31:0] refMem [256];

   int checks   = 0;
   int failures = 0;

   logic        lastHit;
   logic [31:0] lastLoadData;
   logic        lastWe;
   logic [31:0] lastAddr;
   logic [31:0] lastWData;

   always #5 clk = ~clk;

   assign memRData = memArr[memAddr[9:2]];

   arm_write_buffer #(.BusWidth(BusWidth), .Depth(Depth)) dut (
      .i_CLK              (clk),
      .i_RESET_N          (rstN),
      .i_Store_Valid      (storeValid),
      .i_Store_Addr       (storeAddr),
      .i_Store_Data       (storeData),
      .o_Store_Ready      (storeReady),
      .i_Load_Valid       (loadValid),
      .i_Load_Addr        (loadAddr),
      .o_Load_Data        (loadData),
      .o_Load_Hit         (loadHit),
      .o_Mem_Write_Enable (memWe),
      .o_Mem_Address      (memAddr),
      .o_Mem_Write_Data   (memWData),
      .i_Mem_Read_Data    (memRData),
      .o_Empty            (empty),
      .o_Full             (full),
      .o_Count            (count)
   );

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance model and memory at the edge.
   task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic lv, input logic [31:0] la);
      int     fwdIdx;
      int     matchIdx;
      logic   expDrain;
      logic   expReady;
      logic   doCoalesce;
      entry_t e;
      @(negedge clk);
      storeValid = sv;
      storeAddr  = sa;
      storeData  = sd;
      loadValid  = lv;
      loadAddr   = la;
      #1;
      expDrain = !lv && (model.size() != 0);
      fwdIdx   = -1;
      matchIdx = -1;
      for (int i = 0; i < model.size(); i++) begin
         if (model[i].word == la[31:2]) fwdIdx = i;
         if (model[i].word == sa[31:2]) matchIdx = i;
      end
`ifdef ARM_WRITE_BUFFER_COALESCE_EN
      doCoalesce = (matchIdx >= 0) && !(matchIdx == 0 && expDrain);
`else
      doCoalesce = 1'b0;
`endif
      expReady = (model.size() < Depth) || doCoalesce;

      checkOutput("count", 32'(count), 32'(model.size()));
      checkOutput("empty", 32'(empty), 32'(model.size() == 0));
      checkOutput("full", 32'(full), 32'(model.size() == Depth));
      checkOutput("storeReady", 32'(storeReady), 32'(expReady));
      checkOutput("memWe", 32'(memWe), 32'(expDrain));
      if (expDrain) begin
         checkOutput("drainAddr", memAddr, {model[0].word, 2'b00});
         checkOutput("drainData", memWData, model[0].data);
      end else begin
         checkOutput("memAddr", memAddr, la);
      end
      if (lv) begin
         checkOutput("loadHit", 32'(loadHit), 32'(fwdIdx >= 0));
         checkOutput("loadData", loadData, (fwdIdx >= 0) ? model[fwdIdx].data : refMem[la[9:2]]);
      end else begin
         checkOutput("loadHitIdle", 32'(loadHit), 32'd0);
      end

      lastHit      = loadHit;
      lastLoadData = loadData;
      lastWe       = memWe;
      lastAddr     = memAddr;
      lastWData    = memWData;

      if (sv && expReady && doCoalesce) begin
         e = model[matchIdx];
         e.data = sd;
         model[matchIdx] = e;
      end
      if (expDrain) begin
         refMem[model[0].word[7:0]] = model[0].data;
         void'(model.pop_front());
      end
      if (sv && expReady && !doCoalesce) begin
         e.word = sa[31:2];
         e.data = sd;
         model.push_back(e);
      end

      @(posedge clk);
      if (memWe) memArr[memAddr[9:2]] = memWData;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         memArr[i] = $urandom;
         refMem[i] = memArr[i];
      end
      rstN       = 1'b0;
      storeValid = 1'b0;
      storeAddr  = '0;
      storeData  = '0;
      loadValid  = 1'b0;
      loadAddr   = '0;
      #1;
      checkOutput("rstEmpty", 32'(empty), 32'd1);
      checkOutput("rstCount", 32'(count), 32'd0);
      checkOutput("rstFull", 32'(full), 32'd0);
      checkOutput("rstMemWe", 32'(memWe), 32'd0);
      checkOutput("rstReady", 32'(storeReady), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;

      // Single store drains on the following cycle.
      applyStimulus(1'b1, 32'h10, 32'hAAAA5555, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("planWe", 32'(lastWe), 32'd1);
      checkOutput("planAddr", lastAddr, 32'h10);
      checkOutput("planWData", lastWData, 32'hAAAA5555);
      #1;
      checkOutput("planEmpty", 32'(empty), 32'd1);
      checkOutput("planMem4", memArr[4], 32'hAAAA5555);

      // Fill under a held load, then drain in order.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b1, 32'h100);
      #1;
      checkOutput("fillCount", 32'(count), 32'd4);
      checkOutput("fillFull", 32'(full), 32'd1);
      applyStimulus(1'b1, 32'h14, 32'hBAD0BAD0, 1'b1, 32'h100);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
         checkOutput("orderAddr", lastAddr, 32'(i * 4));
      end
      #1;
      checkOutput("drainedEmpty", 32'(empty), 32'd1);

`ifdef ARM_WRITE_BUFFER_COALESCE_EN
      applyStimulus(1'b1, 32'h30, 32'h7, 1'b1, 32'h100);
      applyStimulus(1'b1, 32'h30, 32'h9, 1'b1, 32'h100);
      #1;
      checkOutput("coalCount", 32'(count), 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      checkOutput("coalAddr", lastAddr, 32'h30);
      checkOutput("coalData", lastWData, 32'h9);
      #1;
      checkOutput("coalEmpty", 32'(empty), 32'd1);
`else
      applyStimulus(1'b1, 32'h20, 32'h1, 1'b1, 32'h100);
      applyStimulus(1'b1, 32'h20, 32'h2, 1'b1, 32'h100);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h23);
      checkOutput("fwdHit", 32'(lastHit), 32'd1);
      checkOutput("fwdData", lastLoadData, 32'h2);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
      checkOutput("fwdMissHit", 32'(lastHit), 32'd0);
      checkOutput("fwdMissData", lastLoadData, refMem[9]);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`endif

      // Accept and drain in the same cycle keep the occupancy steady.
      applyStimulus(1'b1, 32'h50, 32'h51, 1'b1, 32'h100);
      applyStimulus(1'b1, 32'h54, 32'h55, 1'b1, 32'h100);
      applyStimulus(1'b1, 32'h58, 32'h59, 1'b0, 32'h0);
      #1;
      checkOutput("steadyCount", 32'(count), 32'd2);
      for (int i = 0; i < 2 * Depth; i++) applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'($urandom), 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Asynchronous reset mid-cycle discards three pending stores.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'hDEAD0000 + 32'(i), 1'b1, 32'h100);
      @(negedge clk);
      storeValid = 1'b0;
      loadValid  = 1'b0;
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("asyncCount", 32'(count), 32'd0);
      checkOutput("asyncEmpty", 32'(empty), 32'd1);
      checkOutput("asyncMemWe", 32'(memWe), 32'd0);
      checkOutput("asyncReady", 32'(storeReady), 32'd1);
      model.delete();
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) checkOutput("discarded", memArr[16 + i], refMem[16 + i]);

      // Random traffic with three levels of load pressure.
      for (int phase = 0; phase < 3; phase++) begin
         for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(0, 99) < 60), 32'($urandom_range(0, 63)), 32'($urandom),
                          ($urandom_range(0, 99) < 20 + 35 * phase), 32'($urandom_range(0, 127)));
         end
      end
      for (int i = 0; i < Depth + 2; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("finalEmpty", 32'(empty), 32'd1);
      for (int i = 0; i < 256; i++) checkOutput("finalMem", memArr[i], refMem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/arm_write_buffer.md
Name: arm_write_buffer

Overview:
- Posted-store FIFO between the single-cycle core's memory stage and the ARM data memory.
- Stores retire into the buffer in one cycle. The buffer drains them into the data memory's single write port whenever the port is not needed by a load.
- Loads that hit a pending store are forwarded from the buffer, so the core always sees program-order memory.

Parameters:
- BusWidth, 32, data/address width in bits.
- Depth, 4, number of buffer entries; power of two, at least 2.

Ports:
- i_CLK  in  1  clock; all state updates on posedge.
- i_RESET_N  in  1  asynchronous, active-low reset.
- i_Store_Valid  in  1  core requests a word store this cycle.
- i_Store_Addr  in  BusWidth  store byte address; bits [1:0] ignored.
- i_Store_Data  in  BusWidth  store data.
- o_Store_Ready  out  1  buffer can accept a store this cycle.
- i_Load_Valid  in  1  core performs a load this cycle.
- i_Load_Addr  in  BusWidth  load byte address; bits [1:0] ignored.
- o_Load_Data  out  BusWidth  load result, forwarded or from memory.
- o_Load_Hit  out  1  load was satisfied from the buffer.
- o_Mem_Write_Enable  out  1  to data memory write enable.
- o_Mem_Address  out  BusWidth  to data memory address.
- o_Mem_Write_Data  out  BusWidth  to data memory write data.
- i_Mem_Read_Data  in  BusWidth  from data memory (combinational read).
- o_Empty  out  1  no pending stores; core uses this as a fence/halt condition.
- o_Full  out  1  all Depth entries occupied.
- o_Count  out  $clog2(Depth+1)  number of occupied entries.

Behaviour:
- Storage and reset:
  - Circular FIFO with head/tail pointers of width $clog2(Depth) and a separate count; pointers wrap modulo Depth.
  - Each entry holds a word address (bits [BusWidth-1:2]) and data.
  - Asynchronous reset: head, tail and count go to 0; all pending stores are discarded, including a reset mid-drain. Entry contents need not reset.
  - Reset values: o_Empty=1, o_Full=0, o_Count=0, o_Mem_Write_Enable=0, o_Store_Ready=1.
- Store acceptance:
  - o_Store_Ready = !o_Full. It is registered-state only and does not depend on a same-cycle drain.
  - A store is accepted when i_Store_Valid && o_Store_Ready. It writes entry[tail] and advances tail at the clock edge.
  - A store while full is not accepted; the core must stall.
- Memory port arbitration (combinational, loads have priority):
  - If i_Load_Valid: o_Mem_Address = i_Load_Addr and o_Mem_Write_Enable = 0.
  - Else if count != 0: o_Mem_Address = {head word address, 2'b00}, o_Mem_Write_Data = head data, o_Mem_Write_Enable = 1. Head advances and count decrements at the edge (drain).
  - Else: o_Mem_Write_Enable = 0 and o_Mem_Address = i_Load_Addr.
- Forwarding:
  - All valid entries are compared on the word address. The youngest matching entry (nearest to tail) is selected.
  - o_Load_Hit = i_Load_Valid && match. o_Load_Data = hit ? entry data : i_Mem_Read_Data.
  - A store accepted in the same cycle is not visible to that cycle's load.
- Count update: +1 on accept without drain, -1 on drain without accept, unchanged when both or neither occur.
- Flags: o_Full = (count == Depth); o_Empty = (count == 0).
- Simultaneous events:
  - Accept and drain together when not full: both occur, count unchanged.
  - A load stalls draining for as long as i_Load_Valid stays high. Drain latency is therefore unbounded under continuous loads, which is permitted.
- Latency: a store reaches memory no earlier than the edge after acceptance.

Optional Feature:
- Macro ARM_WRITE_BUFFER_COALESCE_EN.
- When defined:
  - An accepted store whose word address matches a valid entry overwrites that entry's data. Tail and count are unchanged.
  - Exception: if the matching entry is the head and it is draining this cycle, a new entry is allocated instead.
  - o_Store_Ready = !o_Full || store_matches_nondraining_entry.
  - At most one entry per word address exists.
- When undefined: every accepted store allocates a new entry; duplicate addresses are allowed and forwarding picks the youngest.

Test Plan:
- Reset -> o_Empty=1, o_Count=0, o_Mem_Write_Enable=0. Store 0x10=0xAAAA5555 with no load -> next cycle o_Mem_Write_Enable=1, o_Mem_Address=0x10, o_Mem_Write_Data=0xAAAA5555. One cycle later o_Empty=1 and memory word 4 = 0xAAAA5555.
- Hold i_Load_Valid=1 to 0x100 and issue 4 stores to 0x0,0x4,0x8,0xC -> o_Full=1, o_Store_Ready=0, 5th store not accepted. Drop the load -> the four stores drain in order, 4 cycles, o_Count decrements 4 to 0.
- Buffer 0x20=0x1, then 0x20=0x2 (coalesce off) with load held -> load 0x23 gives o_Load_Hit=1, o_Load_Data=0x2. Load 0x24 gives o_Load_Hit=0, o_Load_Data = memory word 9.
- With ARM_WRITE_BUFFER_COALESCE_EN and load held: stores 0x30=0x7 then 0x30=0x9 -> o_Count=1. Release the load -> a single write of 0x9 to 0x30.
- With count=2 and no load, accept a store in the same cycle as a drain -> o_Count stays 2 and head/tail each advance by 1. Wrap-around verified after 2*Depth stores.
- Assert i_RESET_N=0 asynchronously mid-cycle with count=3 -> outputs reset immediately. After release, o_Empty=1 and the discarded stores are never written to memory.
